accum_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute sequencer for the 3-bit-opcode accumulator datapath. It owns the program counter and instruction register, and drives a single shared memory port through a req/ack handshake for both instruction fetch and operand read. Decoded control goes to the accumulator/ALU as a registered opcode plus a one-cycle load strobe. The block sits between the unified program/data memory and the accumulator datapath, replacing the single-cycle decode path.

---
 rtl/accum_sequencer.sv | 155 +++++++++++++++
 tb/tb_accum_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_sequencer.sv
// accum_sequencer: multi-cycle fetch/decode/execute sequencer driving one shared req/ack memory port.
// Define ACCUM_SEQ_PERF_CNT_EN to build the 16-bit retired-instruction counter; otherwise instr_retired is 0.
module accum_sequencer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] operand,
    output logic              ld_ac,
    output logic              busy,
    output logic [15:0]       instr_retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPREAD,
        S_EXEC
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q;
    logic [2:0]        alu_op_q;
    logic [DATA_W-1:0] operand_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              ld_ac_q;
    logic              busy_q;

    logic [2:0]        opcode_d;
    logic [ADDR_W-1:0] ir_addr_d;
    logic              is_jump_d;

    assign opcode_d  = ir_q[DATA_W-1 -: 3];
    assign ir_addr_d = ir_q[ADDR_W-1:0];
    assign is_jump_d = (opcode_d == 3'b111);

    // Outputs are registered alongside the state, so they are set on the transition into each state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            alu_op_q   <= '0;
            operand_q  <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            ld_ac_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ld_ac_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_q    <= S_FETCH;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_q;
                        busy_q     <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        ir_q      <= mem_rdata;
                        alu_op_q  <= mem_rdata[DATA_W-1 -: 3];
                        pc_q      <= pc_q + ADDR_W'(1);
                        mem_req_q <= 1'b0;
                        state_q   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_jump_d) begin
                        pc_q <= ir_addr_d;
                        if (stop) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q    <= S_FETCH;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= ir_addr_d;
                        end
                    end else begin
                        state_q    <= S_OPREAD;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= ir_addr_d;
                    end
                end
                S_OPREAD: begin
                    if (mem_ack) begin
                        operand_q <= mem_rdata;
                        mem_req_q <= 1'b0;
                        ld_ac_q   <= 1'b1;
                        state_q   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q    <= S_FETCH;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_q;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef ACCUM_SEQ_PERF_CNT_EN
    logic [15:0] retired_q;
    logic        retire_d;

    // A jump retires in DECODE; every other instruction retires in EXEC.
    assign retire_d = (state_q == S_EXEC) || ((state_q == S_DECODE) && is_jump_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else if (retire_d) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    assign instr_retired = retired_q;
`else
    assign instr_retired = '0;
`endif

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign alu_op   = alu_op_q;
    assign operand  = operand_q;
    assign ld_ac    = ld_ac_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_accum_sequencer.sv
// Self-checking bench for accum_sequencer: directed program plus randomized memory contents and ack delays,
// checked against an instruction-level model of the sequencer's memory traffic and architectural state.
module tb_accum_sequencer;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int MEM_N = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] pc;
    logic [DW-1:0] ir;
    logic [2:0]    alu_op;
    logic [DW-1:0] operand;
    logic          ld_ac;
    logic          busy;
    logic [15:0]   instr_retired;

    accum_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .pc            (pc),
        .ir            (ir),
        .alu_op        (alu_op),
        .operand       (operand),
        .ld_ac         (ld_ac),
        .busy          (busy),
        .instr_retired (instr_retired)
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] mem [MEM_N];
    int            mpc;
    int            exp_ret;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_counter();
        logic [15:0] v;
        v = '0;
`ifdef ACCUM_SEQ_PERF_CNT_EN
        v = exp_ret[15:0];
`endif
        return v;
    endfunction

    // Executes one instruction starting at the first FETCH cycle. df/dop are ack delays in cycles.
    task automatic run_instr(input int df, input int dop, input bit stop_end);
        logic [DW-1:0] instr;
        int            addr;
        int            cyc;
        cyc = 0;
        for (int i = 0; i <= df; i++) begin
            chk("fetch_req", 32'(mem_req), 32'd1);
            chk("fetch_addr", 32'(mem_addr), 32'(mpc));
            chk("fetch_ld", 32'(ld_ac), 32'd0);
            chk("fetch_busy", 32'(busy), 32'd1);
            mem_ack   = (i == df);
            mem_rdata = (i == df) ? mem[mpc] : DW'($urandom);
            tick();
            cyc++;
        end
        mem_ack = 1'b0;
        instr   = mem[mpc];
        mpc     = (mpc + 1) % MEM_N;
        stop    = stop_end;
        chk("dec_req", 32'(mem_req), 32'd0);
        chk("dec_ir", 32'(ir), 32'(instr));
        chk("dec_op", 32'(alu_op), 32'(instr[DW-1 -: 3]));
        chk("dec_pc", 32'(pc), 32'(mpc));
        chk("dec_ld", 32'(ld_ac), 32'd0);
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = DW'($urandom);
        tick();
        cyc++;
        mem_ack = 1'b0;
        if (instr[DW-1 -: 3] == 3'b111) begin
            mpc = int'(instr[AW-1:0]);
            exp_ret++;
            chk("jmp_pc", 32'(pc), 32'(mpc));
            chk("jmp_ld", 32'(ld_ac), 32'd0);
            chk("jmp_cycles", 32'(cyc), 32'(df + 2));
        end else begin
            addr = int'(instr[AW-1:0]);
            for (int i = 0; i <= dop; i++) begin
                chk("op_req", 32'(mem_req), 32'd1);
                chk("op_addr", 32'(mem_addr), 32'(addr));
                chk("op_ld", 32'(ld_ac), 32'd0);
                mem_ack   = (i == dop);
                mem_rdata = (i == dop) ? mem[addr] : DW'($urandom);
                tick();
                cyc++;
            end
            mem_ack = 1'b0;
            chk("exec_ld", 32'(ld_ac), 32'd1);
            chk("exec_operand", 32'(operand), 32'(mem[addr]));
            chk("exec_op", 32'(alu_op), 32'(instr[DW-1 -: 3]));
            chk("exec_pc", 32'(pc), 32'(mpc));
            chk("exec_req", 32'(mem_req), 32'd0);
            exp_ret++;
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = DW'($urandom);
            tick();
            cyc++;
            mem_ack = 1'b0;
            chk("ld_pulse", 32'(ld_ac), 32'd0);
            chk("instr_cycles", 32'(cyc), 32'(df + dop + 4));
        end
        chk("retired", 32'(instr_retired), 32'(exp_counter()));
        if (stop_end) begin
            chk("stop_busy", 32'(busy), 32'd0);
            chk("stop_req", 32'(mem_req), 32'd0);
            stop = 1'b0;
        end
    endtask

    task automatic restart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        exp_ret   = 0;
        mpc       = 0;
        for (int i = 0; i < MEM_N; i++) mem[i] = 8'h00;
        mem[0]  = 8'h03;
        mem[1]  = 8'hE4;
        mem[3]  = 8'hA5;
        mem[4]  = 8'hFF;
        mem[5]  = 8'h3C;
        mem[31] = 8'h45;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_ir", 32'(ir), 32'd0);
        chk("rst_operand", 32'(operand), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_ld", 32'(ld_ac), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_retired", 32'(instr_retired), 32'd0);

        // start while stop is high must not leave IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        chk("idle_stop_busy", 32'(busy), 32'd0);
        chk("idle_stop_req", 32'(mem_req), 32'd0);
        stop = 1'b0;
        tick();
        start = 1'b0;
        chk("start_req", 32'(mem_req), 32'd1);
        chk("start_addr", 32'(mem_addr), 32'd0);

        // reset in the middle of an operand read
        mem_ack   = 1'b1;
        mem_rdata = mem[0];
        tick();
        mem_ack = 1'b0;
        tick();
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        chk("pre_rst_addr", 32'(mem_addr), 32'd3);
        rst = 1'b1;
        tick();
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_pc", 32'(pc), 32'd0);
        chk("midrst_ir", 32'(ir), 32'd0);
        tick();
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 8'h77;
        tick();
        mem_ack = 1'b0;
        chk("late_ack_busy", 32'(busy), 32'd0);
        chk("late_ack_req", 32'(mem_req), 32'd0);
        chk("late_ack_operand", 32'(operand), 32'd0);
        chk("late_ack_ld", 32'(ld_ac), 32'd0);
        tick();
        chk("late_ack_ld2", 32'(ld_ac), 32'd0);
        chk("late_ack_retired", 32'(instr_retired), 32'd0);

        // directed program: load, jump, jump to 31, wait-state load with PC wrap, stop
        mpc = 0;
        restart();
        run_instr(0, 0, 1'b0);
        run_instr(0, 0, 1'b0);
        run_instr(1, 0, 1'b0);
        run_instr(3, 2, 1'b0);
        chk("wrap_pc", 32'(pc), 32'd0);
        run_instr(0, 1, 1'b1);

        // randomized programs with random ack delays and stops
        for (int i = 0; i < MEM_N; i++) mem[i] = DW'($urandom);
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(3, 12);
            restart();
            for (int k = 0; k < n; k++) begin
                run_instr($urandom_range(0, 3), $urandom_range(0, 3), k == n - 1);
            end
            chk("rand_idle_pc", 32'(pc), 32'(mpc));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
